// File: rtl/arith_arb_pkg.sv
// Shared constants for the two-port add/sub arbiter: opcode encodings,
// port identifiers and the default datapath width.
package arith_arb_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   localparam int WIDTH_DEF = 32;

endpackage : arith_arb_pkg

// File: rtl/arith_addsub.sv
// Shared add/subtract unit: ctrl=0 adds, ctrl=1 computes a + ~b + 1.
// Purely combinational; cout is the carry out of the MSB.
module arith_addsub #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ctrl,
   output logic [WIDTH-1:0] z,
   output logic             cout
);

   logic [WIDTH-1:0] b_eff;

   assign b_eff = b ^ {WIDTH{ctrl}};
   assign {cout, z} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, ctrl};

endmodule : arith_addsub

// File: rtl/arith_rr_pick.sv
// Two-request round-robin picker. On a tie the port not granted last wins;
// the last_grant flop lives in the parent.
module arith_rr_pick
   import arith_arb_pkg::*;
(
   input  logic [1:0] elig,
   input  logic       last_grant,
   output logic [1:0] grant
);

   always_comb begin
      // NOTE: assigning a default before the case keeps every path driven,
      // so no latch is inferred when a case arm is missed.
      grant = 2'b00;
      unique case (elig)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = (last_grant == PORT1) ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule : arith_rr_pick

// File: rtl/arith_share_arb.sv
// Two-port round-robin arbiter in front of one shared add/sub unit, with a
// one-deep response slot per port. Define ARITH_ARB_OVF_EN for signed-overflow outputs.
module arith_share_arb
   import arith_arb_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid0,
   output logic             req_ready0,
   input  logic [WIDTH-1:0] req_a0,
   input  logic [WIDTH-1:0] req_b0,
   input  logic             req_sub0,
   input  logic             req_valid1,
   output logic             req_ready1,
   input  logic [WIDTH-1:0] req_a1,
   input  logic [WIDTH-1:0] req_b1,
   input  logic             req_sub1,
   output logic             rsp_valid0,
   input  logic             rsp_ready0,
   output logic [WIDTH-1:0] rsp_z0,
   output logic             rsp_cout0,
`ifdef ARITH_ARB_OVF_EN
   output logic             rsp_ovf0,
   output logic             rsp_ovf1,
`endif
   output logic             rsp_valid1,
   input  logic             rsp_ready1,
   output logic [WIDTH-1:0] rsp_z1,
   output logic             rsp_cout1
);

   logic [1:0]       slot_valid;
   logic [WIDTH-1:0] slot_z [2];
   logic [1:0]       slot_cout;
   logic             last_grant;

   logic [1:0]       rsp_ready;
   logic [1:0]       elig;
   logic [1:0]       grant;
   logic [1:0]       accept;

   logic [WIDTH-1:0] a_mux;
   logic [WIDTH-1:0] b_mux;
   logic             sub_mux;
   logic [WIDTH-1:0] sum_z;
   logic             sum_cout;

   assign rsp_ready = {rsp_ready1, rsp_ready0};

   // A full slot may still accept when it is being drained this cycle.
   assign elig = {req_valid1, req_valid0} & (~slot_valid | rsp_ready);

   arith_rr_pick u_pick (
      .elig       (elig),
      .last_grant (last_grant),
      .grant      (grant)
   );

   assign accept     = grant & {2{rst_n}};
   assign req_ready0 = accept[PORT0];
   assign req_ready1 = accept[PORT1];

   assign a_mux   = grant[PORT1] ? req_a1   : req_a0;
   assign b_mux   = grant[PORT1] ? req_b1   : req_b0;
   assign sub_mux = grant[PORT1] ? req_sub1 : req_sub0;

   arith_addsub #(.WIDTH(WIDTH)) u_addsub (
      .a    (a_mux),
      .b    (b_mux),
      .ctrl (sub_mux),
      .z    (sum_z),
      .cout (sum_cout)
   );

`ifdef ARITH_ARB_OVF_EN
   logic [1:0]       slot_ovf;
   logic [WIDTH-1:0] b_eff;
   logic             sum_ovf;

   assign b_eff   = (sub_mux == OP_SUB) ? ~b_mux : b_mux;
   assign sum_ovf = (a_mux[WIDTH-1] == b_eff[WIDTH-1]) & (sum_z[WIDTH-1] != a_mux[WIDTH-1]);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         slot_ovf <= 2'b00;
      end else begin
         for (int n = 0; n < 2; n++) begin
            if (accept[n]) slot_ovf[n] <= sum_ovf;
         end
      end
   end

   assign rsp_ovf0 = slot_ovf[PORT0];
   assign rsp_ovf1 = slot_ovf[PORT1];
`endif

   always_ff @(posedge clk) begin
      // NOTE: state flops use non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      if (!rst_n) begin
         slot_valid <= 2'b00;
         slot_cout  <= 2'b00;
         slot_z[0]  <= '0;
         slot_z[1]  <= '0;
         last_grant <= PORT1;
      end else begin
         for (int n = 0; n < 2; n++) begin
            if (accept[n]) begin
               slot_valid[n] <= 1'b1;
               slot_z[n]     <= sum_z;
               slot_cout[n]  <= sum_cout;
            end else if (slot_valid[n] && rsp_ready[n]) begin
               slot_valid[n] <= 1'b0;
            end
         end
         if (|accept) last_grant <= accept[PORT1];
      end
   end

   assign rsp_valid0 = slot_valid[PORT0];
   assign rsp_valid1 = slot_valid[PORT1];
   assign rsp_z0     = slot_z[0];
   assign rsp_z1     = slot_z[1];
   assign rsp_cout0  = slot_cout[PORT0];
   assign rsp_cout1  = slot_cout[PORT1];

endmodule : arith_share_arb

// File: tb/tb_arith_share_arb.sv
// Directed bench for arith_share_arb: single-port vector table, then
// alternation, drain-and-refill and reset sequences.
module tb_arith_share_arb;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req_valid0, req_valid1, req_ready0, req_ready1;
   logic [W-1:0] req_a0, req_b0, req_a1, req_b1;
   logic         req_sub0, req_sub1;
   logic         rsp_valid0, rsp_valid1, rsp_ready0, rsp_ready1;
   logic [W-1:0] rsp_z0, rsp_z1;
   logic         rsp_cout0, rsp_cout1;
`ifdef ARITH_ARB_OVF_EN
   logic         rsp_ovf0, rsp_ovf1;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   arith_share_arb #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid0 (req_valid0),
      .req_ready0 (req_ready0),
      .req_a0     (req_a0),
      .req_b0     (req_b0),
      .req_sub0   (req_sub0),
      .req_valid1 (req_valid1),
      .req_ready1 (req_ready1),
      .req_a1     (req_a1),
      .req_b1     (req_b1),
      .req_sub1   (req_sub1),
      .rsp_valid0 (rsp_valid0),
      .rsp_ready0 (rsp_ready0),
      .rsp_z0     (rsp_z0),
      .rsp_cout0  (rsp_cout0),
`ifdef ARITH_ARB_OVF_EN
      .rsp_ovf0   (rsp_ovf0),
      .rsp_ovf1   (rsp_ovf1),
`endif
      .rsp_valid1 (rsp_valid1),
      .rsp_ready1 (rsp_ready1),
      .rsp_z1     (rsp_z1),
      .rsp_cout1  (rsp_cout1)
   );

   typedef struct {
      bit           port;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
      logic [W-1:0] z;
      logic         cout;
      logic         ovf;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Advance one clock edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [W-1:0] held_z0;

   initial begin
      vecs[0] = '{1'b0, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
      vecs[3] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      vecs[4] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
      vecs[5] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      vecs[6] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
      vecs[7] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

      // Reset with both ports requesting: readies forced low.
      rst_n = 1'b0;
      req_valid0 = 1'b1; req_valid1 = 1'b1;
      req_a0 = '0; req_b0 = '0; req_sub0 = 1'b0;
      req_a1 = '0; req_b1 = '0; req_sub1 = 1'b0;
      rsp_ready0 = 1'b1; rsp_ready1 = 1'b1;
      #1;
      check("rst_ready0", {31'b0, req_ready0}, 32'd0);
      check("rst_ready1", {31'b0, req_ready1}, 32'd0);
      step();
      check("rst_valid0", {31'b0, rsp_valid0}, 32'd0);
      check("rst_valid1", {31'b0, rsp_valid1}, 32'd0);
      check("rst_z0", rsp_z0, 32'd0);
      check("rst_z1", rsp_z1, 32'd0);
      check("rst_cout0", {31'b0, rsp_cout0}, 32'd0);
      check("rst_cout1", {31'b0, rsp_cout1}, 32'd0);
`ifdef ARITH_ARB_OVF_EN
      check("rst_ovf0", {31'b0, rsp_ovf0}, 32'd0);
      check("rst_ovf1", {31'b0, rsp_ovf1}, 32'd0);
`endif
      req_valid0 = 1'b0; req_valid1 = 1'b0;
      rst_n = 1'b1;
      step();

      // Single-port vectors; consumer always ready.
      for (int i = 0; i < 8; i++) begin
         if (vecs[i].port) begin
            req_valid1 = 1'b1; req_a1 = vecs[i].a; req_b1 = vecs[i].b; req_sub1 = vecs[i].sub;
         end else begin
            req_valid0 = 1'b1; req_a0 = vecs[i].a; req_b0 = vecs[i].b; req_sub0 = vecs[i].sub;
         end
         #1;
         check($sformatf("v%0d_ready", i), {31'b0, vecs[i].port ? req_ready1 : req_ready0}, 32'd1);
         check($sformatf("v%0d_other_ready", i), {31'b0, vecs[i].port ? req_ready0 : req_ready1}, 32'd0);
         step();
         req_valid0 = 1'b0; req_valid1 = 1'b0;
         check($sformatf("v%0d_valid", i), {31'b0, vecs[i].port ? rsp_valid1 : rsp_valid0}, 32'd1);
         check($sformatf("v%0d_z", i), vecs[i].port ? rsp_z1 : rsp_z0, vecs[i].z);
         check($sformatf("v%0d_cout", i), {31'b0, vecs[i].port ? rsp_cout1 : rsp_cout0}, {31'b0, vecs[i].cout});
`ifdef ARITH_ARB_OVF_EN
         check($sformatf("v%0d_ovf", i), {31'b0, vecs[i].port ? rsp_ovf1 : rsp_ovf0}, {31'b0, vecs[i].ovf});
`endif
         step();
         check($sformatf("v%0d_drained", i), {31'b0, vecs[i].port ? rsp_valid1 : rsp_valid0}, 32'd0);
      end

      // Port 0 slot full and held: port 1 wins every cycle.
      req_valid0 = 1'b1; req_a0 = 32'd100; req_b0 = 32'd23; req_sub0 = 1'b0;
      rsp_ready0 = 1'b0;
      step();
      held_z0 = 32'd123;
      check("hold_fill_z0", rsp_z0, held_z0);
      req_a0 = 32'd1; req_b0 = 32'd1;
      req_valid1 = 1'b1; req_sub1 = 1'b0; req_b1 = 32'd1;
      for (int i = 0; i < 3; i++) begin
         req_a1 = 32'(i * 16);
         #1;
         check($sformatf("hold%0d_ready0", i), {31'b0, req_ready0}, 32'd0);
         check($sformatf("hold%0d_ready1", i), {31'b0, req_ready1}, 32'd1);
         step();
         check($sformatf("hold%0d_z0", i), rsp_z0, held_z0);
         check($sformatf("hold%0d_z1", i), rsp_z1, 32'(i * 16 + 1));
      end
      // Drain and refill: port 0 wins the tie since port 1 went last.
      rsp_ready0 = 1'b1;
      #1;
      check("refill_ready0", {31'b0, req_ready0}, 32'd1);
      check("refill_ready1", {31'b0, req_ready1}, 32'd0);
      step();
      check("refill_valid0", {31'b0, rsp_valid0}, 32'd1);
      check("refill_z0", rsp_z0, 32'd2);

      // Fill both slots, then reset mid-operation.
      rsp_ready0 = 1'b0; rsp_ready1 = 1'b0;
      req_a0 = 32'd7; req_a1 = 32'd9;
      step();
      step();
      check("full_valid0", {31'b0, rsp_valid0}, 32'd1);
      check("full_valid1", {31'b0, rsp_valid1}, 32'd1);
      rsp_ready0 = 1'b1; rsp_ready1 = 1'b1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_ready0", {31'b0, req_ready0}, 32'd0);
      check("mid_rst_ready1", {31'b0, req_ready1}, 32'd0);
      step();
      check("mid_rst_valid0", {31'b0, rsp_valid0}, 32'd0);
      check("mid_rst_valid1", {31'b0, rsp_valid1}, 32'd0);
      rst_n = 1'b1;

      // Both always valid after reset: grants alternate starting with port 0.
      req_sub0 = 1'b0; req_sub1 = 1'b1; req_a1 = 32'd100;
      for (int i = 0; i < 4; i++) begin
         req_a0 = 32'(10 + i); req_b0 = 32'(i);
         req_b1 = 32'(i);
         #1;
         check($sformatf("alt%0d_ready0", i), {31'b0, req_ready0}, {31'b0, (i % 2) == 0});
         check($sformatf("alt%0d_ready1", i), {31'b0, req_ready1}, {31'b0, (i % 2) == 1});
         step();
         if ((i % 2) == 0) check($sformatf("alt%0d_z0", i), rsp_z0, 32'(10 + 2 * i));
         else              check($sformatf("alt%0d_z1", i), rsp_z1, 32'(100 - i));
      end

      req_valid0 = 1'b0; req_valid1 = 1'b0;
      step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_arith_share_arb
